// File: rtl/conv_window_ctrl.sv
// 3x3 convolution window controller: walks pixel row/col over an IMG_W x IMG_H frame
// and presents window coordinates. Define CONV_STRIDE2_EN for stride-2 windows.
module conv_window_ctrl #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          lb_shift_en,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    logic [CW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          busy_q;
    logic          frame_done_q;
    logic          win_hit;

    // Accept pixels only while running and no window is stalled downstream.
    assign in_ready    = (state_q == RUN) && !(win_valid_q && !win_ready);
    assign lb_shift_en = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_hit     = 1'b0;

        case (state_q)
            IDLE: begin
                // A start is dropped while the previous frame's window is unconsumed.
                if (start && !win_valid_q) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (lb_shift_en) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + ONE;
                        if (row_q == ROW_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CONV_STRIDE2_EN
        // row-2 and col-2 even is the same as row and col even.
        win_hit = lb_shift_en && (row_q >= TWO) && (col_q >= TWO) && !row_q[0] && !col_q[0];
`else
        win_hit = lb_shift_en && (row_q >= TWO) && (col_q >= TWO);
`endif

        // A new window wins over consumption of the current one.
        if (win_hit) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - TWO;
            win_col_d   = col_q - TWO;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            busy_q       <= (state_d == RUN);
            frame_done_q <= (state_d == DONE);
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: pixel-index reference model, window-order scoreboard,
// directed frames (stall, reset, start pokes) and randomized handshake frames.
module tb_conv_window_ctrl;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int CW   = 5;
    localparam int NPIX = W * H;
`ifdef CONV_STRIDE2_EN
    localparam int EXP_NWIN = 169;
    localparam int STALL_R  = 2;
`else
    localparam int EXP_NWIN = 676;
    localparam int STALL_R  = 3;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          lb_shift_en;
    logic          win_valid;
    logic          win_ready;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          busy;
    logic          frame_done;

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lb_shift_en(lb_shift_en),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_lb_shift_en"}, int'(lb_shift_en), 0);
        chk({tag, "_win_valid"}, int'(win_valid), 0);
        chk({tag, "_win_row"}, int'(win_row), 0);
        chk({tag, "_win_col"}, int'(win_col), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // Reference model: mode 0 idle, 1 running, 2 done; pixel position from a flat index.
    int m_mode = 0;
    int m_pix  = 0;
    int m_wv   = 0;
    int m_wr   = 0;
    int m_wc   = 0;
    int exp_r[$];
    int exp_c[$];
    int exp_k  = 0;

    int n_cyc          = 0;
    int last_shift_cyc = 0;
    int dut_pix        = 0;
    int dut_sh_tot     = 0;
    int dut_hs_tot     = 0;
    int dut_fd_tot     = 0;
    int prev_acc       = -1;
    int prev_wr        = 0;

    always @(negedge clk) begin : cmp
        int e_ir;
        int r;
        int c;
        int hit;
        e_ir = 0;
        r    = 0;
        c    = 0;
        hit  = 0;
        n_cyc++;
        if (!rst) begin
            chk_zero("rst_cyc");
            m_mode   = 0;
            m_pix    = 0;
            m_wv     = 0;
            m_wr     = 0;
            m_wc     = 0;
            dut_pix  = 0;
            prev_acc = -1;
            prev_wr  = 0;
        end else begin
            e_ir = (m_mode == 1 && !(m_wv != 0 && !win_ready)) ? 1 : 0;
            chk("in_ready", int'(in_ready), e_ir);
            chk("lb_shift_en", int'(lb_shift_en), (e_ir != 0 && in_valid) ? 1 : 0);
            chk("busy", int'(busy), (m_mode == 1) ? 1 : 0);
            chk("frame_done", int'(frame_done), (m_mode == 2) ? 1 : 0);
            chk("win_valid", int'(win_valid), m_wv);
            if (m_wv != 0) begin
                chk("win_row", int'(win_row), m_wr);
                chk("win_col", int'(win_col), m_wc);
            end

            // Hand-computed pins on specific pixel indices (index = row*28 + col).
            if (prev_acc == 58) begin
                chk("first_win_valid", int'(win_valid), 1);
                chk("first_win_row", int'(win_row), 0);
                chk("first_win_col", int'(win_col), 0);
            end
`ifdef CONV_STRIDE2_EN
            if (prev_acc == 86 && prev_wr != 0) chk("odd_offset_nowin", int'(win_valid), 0);
            if (prev_acc == 754) begin
                chk("last_win_row", int'(win_row), 24);
                chk("last_win_col", int'(win_col), 24);
            end
`else
            if ((prev_acc == 140 || prev_acc == 141) && prev_wr != 0)
                chk("wrap_nowin", int'(win_valid), 0);
            if (prev_acc == 167) begin
                chk("wrap_win_valid", int'(win_valid), 1);
                chk("wrap_win_row", int'(win_row), 3);
                chk("wrap_win_col", int'(win_col), 25);
            end
            if (prev_acc == 170) begin
                chk("newrow_win_row", int'(win_row), 4);
                chk("newrow_win_col", int'(win_col), 0);
            end
`endif

            if (win_valid && win_ready) begin
                dut_hs_tot++;
                chk("win_index_in_range", (exp_k < exp_r.size()) ? 1 : 0, 1);
                if (exp_k < exp_r.size()) begin
                    chk("win_order_row", int'(win_row), exp_r[exp_k]);
                    chk("win_order_col", int'(win_col), exp_c[exp_k]);
                end
                exp_k++;
            end
            if (frame_done) begin
                dut_fd_tot++;
                chk("fd_after_last_pixel", n_cyc - last_shift_cyc, 1);
                chk("fd_pix_count", dut_pix, NPIX);
                dut_pix = 0;
            end
            prev_acc = -1;
            if (lb_shift_en) begin
                prev_acc       = dut_pix;
                dut_pix++;
                dut_sh_tot++;
                last_shift_cyc = n_cyc;
            end
            prev_wr = win_ready ? 1 : 0;

            case (m_mode)
                0: if (start && m_wv == 0) begin
                    m_mode = 1;
                    m_pix  = 0;
                    exp_k  = 0;
                end
                1: if (e_ir != 0 && in_valid) begin
                    r = m_pix / W;
                    c = m_pix % W;
`ifdef CONV_STRIDE2_EN
                    hit = (r >= 2 && c >= 2 && (r - 2) % 2 == 0 && (c - 2) % 2 == 0) ? 1 : 0;
`else
                    hit = (r >= 2 && c >= 2) ? 1 : 0;
`endif
                    if (m_pix == NPIX - 1) m_mode = 2;
                    m_pix++;
                end
                default: m_mode = 0;
            endcase
            if (hit != 0) begin
                m_wv = 1;
                m_wr = r - 2;
                m_wc = c - 2;
            end else if (win_ready) begin
                m_wv = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int pv, input int pr, input bit do_stall, input bit poke,
                             input int rst_at, input bit hold);
        int s_sh;
        int s_hs;
        int s_fd;
        bit done;
        bit stalled;
        bit aborted;
        s_sh    = dut_sh_tot;
        s_hs    = dut_hs_tot;
        s_fd    = dut_fd_tot;
        done    = 1'b0;
        stalled = 1'b0;
        aborted = 1'b0;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        for (int i = 0; i < 30000 && !done && !aborted; i++) begin
            in_valid  = ($urandom_range(99) < pv);
            win_ready = ($urandom_range(99) < pr);
            start     = poke && ($urandom_range(19) == 0);
            if (do_stall && !stalled && win_valid && win_row == CW'(STALL_R) && win_col == CW'(4)) begin
                stalled   = 1'b1;
                win_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(in_ready), 0);
                    chk("stall_valid", int'(win_valid), 1);
                    chk("stall_row", int'(win_row), STALL_R);
                    chk("stall_col", int'(win_col), 4);
                    cyc();
                end
                win_ready = 1'b1;
            end
            if (rst_at >= 0 && dut_pix >= rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                chk_zero("midframe_rst");
                cyc();
                rst       = 1'b1;
                in_valid  = 1'b1;
                win_ready = 1'b1;
                start     = 1'b0;
                repeat (12) cyc();
                chk("no_fd_after_rst", dut_fd_tot - s_fd, 0);
                chk("idle_after_rst_busy", int'(busy), 0);
                aborted = 1'b1;
            end else begin
                cyc();
                if (frame_done) done = 1'b1;
            end
        end
        if (!aborted) begin
            chk("frame_completed", int'(done), 1);
            in_valid  = 1'b0;
            start     = 1'b0;
            win_ready = 1'b1;
`ifndef CONV_STRIDE2_EN
            if (hold) begin
                win_ready = 1'b0;
                cyc();
                cyc();
                chk("pend_valid_in_idle", int'(win_valid), 1);
                start = 1'b1;
                cyc();
                start = 1'b0;
                cyc();
                chk("start_held_off_busy", int'(busy), 0);
                chk("start_held_off_pend", int'(win_valid), 1);
                win_ready = 1'b1;
            end
`endif
            repeat (3) cyc();
            chk("frame_shifts", dut_sh_tot - s_sh, NPIX);
            chk("frame_windows", dut_hs_tot - s_hs, EXP_NWIN);
            chk("frame_done_count", dut_fd_tot - s_fd, 1);
            chk("idle_win_valid_clear", int'(win_valid), 0);
            if (do_stall) chk("stall_seen", int'(stalled), 1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;

        for (int r = 0; r <= H - 3; r++) begin
            for (int c = 0; c <= W - 3; c++) begin
`ifdef CONV_STRIDE2_EN
                if (r % 2 == 0 && c % 2 == 0) begin
                    exp_r.push_back(r);
                    exp_c.push_back(c);
                end
`else
                exp_r.push_back(r);
                exp_c.push_back(c);
`endif
            end
        end
        chk("exp_list_len", exp_r.size(), EXP_NWIN);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        cyc();
        rst = 1'b1;
        repeat (3) cyc();
        chk("idle_busy", int'(busy), 0);
        chk("idle_in_ready", int'(in_ready), 0);

        run_frame(100, 100, 1'b1, 1'b1, -1, 1'b1);
        run_frame(100, 100, 1'b0, 1'b0, 400, 1'b0);
        run_frame(100, 100, 1'b0, 1'b0, -1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            run_frame(75, 60, 1'b0, 1'b1, -1, f[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
